// File: rtl/zeroriscy_ppu_ctrl.sv
// Sequencing controller between the EX stage and the posit unit: captures operands,
// issues a single start pulse, waits for the result (or times out) and hands it back.
module zeroriscy_ppu_ctrl #(
    parameter int unsigned OP_W        = 3,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [31:0]     operand_a_i,
    input  logic [31:0]     operand_b_i,
    input  logic [OP_W-1:0] operator_i,
    input  logic            kill_i,
    output logic            ppu_valid_o,
    output logic [31:0]     ppu_in1_o,
    output logic [31:0]     ppu_in2_o,
    output logic [OP_W-1:0] ppu_op_o,
    input  logic [31:0]     ppu_out_i,
    input  logic            ppu_valid_i,
    output logic [31:0]     result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic            timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      NAR      = 32'h8000_0000;

    state_e          state_q;
    logic [31:0]     in1_q;
    logic [31:0]     in2_q;
    logic [OP_W-1:0] op_q;
    logic [31:0]     result_q;
    logic [CNT_W-1:0] cnt_q;
    logic            ready_q;
    logic            timeout_q;
    logic            cntLast;

    // A kill in the last WAIT cycle enters DRAIN one past the limit, hence >=.
    assign cntLast = (cnt_q >= CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in1_q     <= '0;
            in2_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i && !kill_i) begin
                        in1_q   <= operand_a_i;
                        in2_q   <= operand_b_i;
                        op_q    <= operator_i;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (kill_i) begin
                        state_q <= IDLE;
                    end else if (ppu_valid_i) begin
                        result_q <= ppu_out_i;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (kill_i) begin
                        state_q <= DRAIN;
                    end else if (ppu_valid_i) begin
                        result_q <= ppu_out_i;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else if (cntLast) begin
                        result_q  <= NAR;
                        ready_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                DRAIN: begin
                    // The in-flight result is dropped; result_o keeps the last completion.
                    cnt_q <= cnt_q + 1'b1;
                    if (ppu_valid_i || cntLast) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ppu_valid_o = (state_q == ISSUE) && !kill_i;
    assign ppu_in1_o   = in1_q;
    assign ppu_in2_o   = in2_q;
    assign ppu_op_o    = op_q;
    assign result_o    = result_q;
    assign ready_o     = ready_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_zeroriscy_ppu_ctrl.sv
// Randomized bench for zeroriscy_ppu_ctrl: each instruction's timeline is predicted
// from cycle arithmetic (latency, kill point, timeout limit) and compared every cycle.
module tb_zeroriscy_ppu_ctrl;

    localparam int          T   = 15;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enI;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [2:0]  opCode;
    logic        killI;
    logic        ppuValidO;
    logic [31:0] ppuIn1;
    logic [31:0] ppuIn2;
    logic [2:0]  ppuOp;
    logic [31:0] ppuOut;
    logic        ppuValidI;
    logic [31:0] resultO;
    logic        readyO;
    logic        busyO;
    logic        timeoutO;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expResult;
    logic [31:0] nextA;
    logic [31:0] nextB;
    logic [2:0]  nextOp;

    zeroriscy_ppu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (enI),
        .operand_a_i (opA),
        .operand_b_i (opB),
        .operator_i  (opCode),
        .kill_i      (killI),
        .ppu_valid_o (ppuValidO),
        .ppu_in1_o   (ppuIn1),
        .ppu_in2_o   (ppuIn2),
        .ppu_op_o    (ppuOp),
        .ppu_out_i   (ppuOut),
        .ppu_valid_i (ppuValidI),
        .result_o    (resultO),
        .ready_o     (readyO),
        .busy_o      (busyO),
        .timeout_o   (timeoutO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic newOperands();
        nextA  = $urandom;
        nextB  = $urandom;
        nextOp = 3'($urandom_range(0, 7));
    endtask

    // One instruction, cycle 0 being the IDLE cycle in which en_i is first sampled.
    // lat: result valid lat cycles after the start pulse; killAt: cycle of kill (0 = none).
    task automatic applyStimulus(input int lat, input logic [31:0] data, input bit hung,
                                 input int killAt, input bit killInDone);
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] newRes;
        int          v;
        int          r;
        int          last;
        a      = nextA;
        b      = nextB;
        op     = nextOp;
        v      = 1 + lat;
        r      = hung ? T + 2 : lat + 2;
        newRes = hung ? NAR : data;
        if (killAt == 0)      last = r;
        else if (killAt == 1) last = 1;
        else                  last = hung ? T + 1 : v;
        newOperands();
        for (int c = 0; c <= last; c++) begin
            if (killAt != 0 && c > killAt) begin
                enI = 1'b1; opA = nextA; opB = nextB; opCode = nextOp; killI = 1'b0;
            end else if (killAt != 0 && c == killAt) begin
                enI = 1'b0; killI = 1'b1;
            end else begin
                enI = 1'b1; opA = a; opB = b; opCode = op;
                killI = (killAt == 0) && killInDone && (c == r);
            end
            ppuValidI = !hung && (c == v);
            ppuOut    = (c == v) ? data : $urandom;
            @(negedge clk);
            checkOutput("busy", 32'(busyO), 32'(c >= 1));
            checkOutput("startPulse", 32'(ppuValidO), 32'(c == 1 && killAt != 1));
            checkOutput("ready", 32'(readyO), 32'(killAt == 0 && c == r));
            checkOutput("timeout", 32'(timeoutO), 32'(killAt == 0 && c == r && hung));
            checkOutput("result", resultO, (killAt == 0 && c >= r) ? newRes : expResult);
            if (c >= 1) begin
                checkOutput("ppuIn1", ppuIn1, a);
                checkOutput("ppuIn2", ppuIn2, b);
                checkOutput("ppuOp", 32'(ppuOp), 32'(op));
            end
            @(posedge clk);
            #1;
        end
        if (killAt == 0) expResult = newRes;
        enI = 1'b0; killI = 1'b0; ppuValidI = 1'b0;
    endtask

    // Idle cycles; a stray valid from the unit must be ignored.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            enI       = 1'b0;
            ppuValidI = ($urandom_range(0, 3) == 0);
            ppuOut    = $urandom;
            @(negedge clk);
            checkOutput("idleBusy", 32'(busyO), 32'd0);
            checkOutput("idleReady", 32'(readyO), 32'd0);
            checkOutput("idlePulse", 32'(ppuValidO), 32'd0);
            checkOutput("idleResult", resultO, expResult);
            @(posedge clk);
            #1;
        end
        ppuValidI = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int kind;
        int k;
        int vSel;
        bit wasKill;
        rst_n = 1'b0; enI = 1'b0; opA = '0; opB = '0; opCode = '0;
        killI = 1'b0; ppuOut = '0; ppuValidI = 1'b0;
        expResult = '0;
        #3;
        checkOutput("rstBusy", 32'(busyO), 32'd0);
        checkOutput("rstReady", 32'(readyO), 32'd0);
        checkOutput("rstResult", resultO, 32'd0);
        checkOutput("rstIn1", ppuIn1, 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        nextA = 32'h4000_0000; nextB = 32'h4000_0000; nextOp = 3'd0;
        applyStimulus(3, 32'h4800_0000, 1'b0, 0, 1'b0);
        idleCycles(1);
        newOperands();
        applyStimulus(0, 32'h1234_5678, 1'b0, 0, 1'b0);
        idleCycles(2);
        applyStimulus(0, 32'h0, 1'b1, 0, 1'b0);
        idleCycles(1);
        applyStimulus(5, 32'hBAD0_BAD0, 1'b0, 4, 1'b0);
        applyStimulus(2, 32'h1111_2222, 1'b0, 0, 1'b0);
        applyStimulus(1, 32'h3333_4444, 1'b0, 0, 1'b1);
        applyStimulus(15, 32'h5555_6666, 1'b0, 0, 1'b0);
        applyStimulus(0, 32'h0, 1'b0, 1, 1'b0);
        applyStimulus(4, 32'h7777_8888, 1'b0, 0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            kind    = $urandom_range(0, 9);
            wasKill = 1'b0;
            if (kind <= 5) begin
                applyStimulus($urandom_range(0, T), $urandom, 1'b0, 0, 1'($urandom_range(0, 1)));
            end else if (kind == 6) begin
                applyStimulus(0, 32'h0, 1'b1, 0, 1'($urandom_range(0, 1)));
            end else if (kind == 7) begin
                applyStimulus(0, 32'h0, 1'b1, 1, 1'b0);
                wasKill = 1'b1;
            end else begin
                k    = $urandom_range(2, 10);
                vSel = $urandom_range(k + 1, T + 1);
                applyStimulus(vSel - 1, $urandom, 1'($urandom_range(0, 1)), k, 1'b0);
                wasKill = 1'b1;
            end
            if (!wasKill) idleCycles($urandom_range(0, 2));
        end
        idleCycles(1);

        // Asynchronous reset while an instruction is waiting on a hung unit.
        opA = nextA; opB = nextB; opCode = nextOp; enI = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", 32'(busyO), 32'd0);
        checkOutput("midRstPulse", 32'(ppuValidO), 32'd0);
        checkOutput("midRstReady", 32'(readyO), 32'd0);
        checkOutput("midRstTimeout", 32'(timeoutO), 32'd0);
        checkOutput("midRstResult", resultO, 32'd0);
        checkOutput("midRstIn1", ppuIn1, 32'd0);
        checkOutput("midRstIn2", ppuIn2, 32'd0);
        checkOutput("midRstOp", 32'(ppuOp), 32'd0);
        enI = 1'b0;
        #3;
        rst_n = 1'b1;
        expResult = '0;
        @(posedge clk);
        #1;
        ppuValidI = 1'b1; ppuOut = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("postRstBusy", 32'(busyO), 32'd0);
        @(posedge clk);
        #1;
        ppuValidI = 1'b0;
        @(negedge clk);
        checkOutput("postRstBusy2", 32'(busyO), 32'd0);
        checkOutput("postRstReady", 32'(readyO), 32'd0);
        checkOutput("postRstResult", resultO, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
